// File: rtl/wlm_pkg.sv
// wlm_pkg: shared sizing helpers for the word-level Montgomery reducer.
//   calc_w   - word width W = LOGQ - LOGQH (q = qH*2^W + 1)
//   calc_l   - iteration count L = ceil(LOGQ / W)
//   calc_lat - total pipeline latency for a given set of stage enables
package wlm_pkg;

    // Tile width used by the decomposed (DSP-style) qH*T2 multiply.
    localparam int DSP_W = 17;

    function automatic int calc_w(input int logq, input int logqh);
        return logq - logqh;
    endfunction

    function automatic int calc_l(input int logq, input int logqh);
        int w;
        w = logq - logqh;
        return (logq + w - 1) / w;
    endfunction

    function automatic int calc_lat(input int logq, input int logqh,
                                    input int ff_in, input int ff_sub,
                                    input int ff_mul, input int ff_sum,
                                    input int ff_out);
        return ff_in + calc_l(logq, logqh) * (ff_sub + ff_mul + ff_sum) + ff_out;
    endfunction

endpackage

// File: rtl/wlm_reducer_stage.sv
// wlm_stage: one word-level Montgomery iteration (SUB -> MUL -> SUM).
//   clk, rst : clock, synchronous active-high reset
//   t_in     : running value T (2*LOGQ+1 bits)
//   qh_in    : qH belonging to this operand
//   t_out    : (T >> W) + qH*T2 + c
//   qh_out   : qH delayed to stay aligned with t_out
// Each step has its own register enable; a disabled step is a wire.
module wlm_stage
    import wlm_pkg::*;
#(
    parameter int LOGQ   = 60,
    parameter int LOGQH  = 43,
    parameter int FF_SUB = 1,
    parameter int FF_MUL = 1,
    parameter int FF_SUM = 1,
    parameter int MIXED  = 0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [2*LOGQ:0]    t_in,
    input  logic [LOGQH-1:0]   qh_in,
    output logic [2*LOGQ:0]    t_out,
    output logic [LOGQH-1:0]   qh_out
);
    localparam int W  = calc_w(LOGQ, LOGQH);
    localparam int TW = 2*LOGQ + 1;
    localparam int HW = TW - W;
    localparam int SB = HW + W + 1 + LOGQH;
    localparam int MB = HW + LOGQ + 1 + LOGQH;
    localparam int OB = TW + LOGQH;

    // ---- SUB: T2 = -T1 mod 2^W; carry is set whenever T1 is nonzero,
    // since T1 + T2 then equals exactly 2^W.
    logic [W-1:0] t1, t2;
    logic         cy;
    assign t1 = t_in[W-1:0];
    assign t2 = W'(0) - t1;
    assign cy = t1[W-1] | t2[W-1];

    logic [SB-1:0] sub_d, sub_q;
    assign sub_d = {t_in[TW-1:W], t2, cy, qh_in};

    generate
        if (FF_SUB != 0) begin : g_sub_ff
            always_ff @(posedge clk) begin
                if (rst) sub_q <= '0;
                else     sub_q <= sub_d;
            end
        end else begin : g_sub_wire
            assign sub_q = sub_d;
        end
    endgenerate

    logic [HW-1:0]    s_hi;
    logic [W-1:0]     s_t2;
    logic             s_c;
    logic [LOGQH-1:0] s_qh;
    assign {s_hi, s_t2, s_c, s_qh} = sub_q;

    // ---- MUL: P = qH*T2 fits exactly in LOGQ bits (LOGQH + W = LOGQ).
    logic [LOGQ-1:0] p;

    generate
        if (MIXED != 0) begin : g_mul_tiled
            localparam int NT = (LOGQH + DSP_W - 1) / DSP_W;
            localparam int PW = NT*DSP_W + W + 1;
            logic [NT*DSP_W-1:0] qh_ext;
            logic [PW-1:0]       acc;
            assign qh_ext = (NT*DSP_W)'(s_qh);
            // Sum of shifted DSP_W x W partial products.
            always_comb begin
                acc = '0;
                for (int k = 0; k < NT; k++)
                    acc = acc + ((PW'(qh_ext[k*DSP_W +: DSP_W]) * PW'(s_t2)) << (k*DSP_W));
            end
            assign p = acc[LOGQ-1:0];
            wire unused_acc = ^acc[PW-1:LOGQ];
        end else begin : g_mul_native
            assign p = LOGQ'(s_qh) * LOGQ'(s_t2);
        end
    endgenerate

    logic [MB-1:0] mul_d, mul_q;
    assign mul_d = {s_hi, p, s_c, s_qh};

    generate
        if (FF_MUL != 0) begin : g_mul_ff
            always_ff @(posedge clk) begin
                if (rst) mul_q <= '0;
                else     mul_q <= mul_d;
            end
        end else begin : g_mul_wire
            assign mul_q = mul_d;
        end
    endgenerate

    logic [HW-1:0]    m_hi;
    logic [LOGQ-1:0]  m_p;
    logic             m_c;
    logic [LOGQH-1:0] m_qh;
    assign {m_hi, m_p, m_c, m_qh} = mul_q;

    // ---- SUM: (T + q*T2) / 2^W, with the low word folded into the carry.
    logic [TW-1:0] sum_t;
    assign sum_t = TW'(m_hi) + TW'(m_p) + TW'(m_c);

    logic [OB-1:0] sum_d, sum_q;
    assign sum_d = {sum_t, m_qh};

    generate
        if (FF_SUM != 0) begin : g_sum_ff
            always_ff @(posedge clk) begin
                if (rst) sum_q <= '0;
                else     sum_q <= sum_d;
            end
        end else begin : g_sum_wire
            assign sum_q = sum_d;
        end
    endgenerate

    assign {t_out, qh_out} = sum_q;

endmodule

// File: rtl/wlm_reducer.sv
// wlm_reducer: pipelined word-level Montgomery reducer,
// T = C * 2^(-W*L) mod q with q = qH*2^W + 1.
//   clk : clock
//   rst : synchronous active-high reset (clears every pipeline register)
//   qH  : upper part of q, travels with its own C
//   C   : 2*LOGQ-bit value to reduce, C < q^2
//   T   : LOGQ-bit result, LAT cycles after C
module wlm_reducer
    import wlm_pkg::*;
#(
    parameter int LOGQ    = 60,
    parameter int LOGQH   = 43,
    parameter int CORRECT = 1,
    parameter int FF_IN   = 1,
    parameter int FF_SUB  = 1,
    parameter int FF_MUL  = 1,
    parameter int FF_SUM  = 1,
    parameter int FF_OUT  = 1,
    parameter int MIXED   = 0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [LOGQH-1:0]   qH,
    input  logic [2*LOGQ-1:0]  C,
    output logic [LOGQ-1:0]    T
);
    localparam int W   = calc_w(LOGQ, LOGQH);
    localparam int L   = calc_l(LOGQ, LOGQH);
    localparam int TW  = 2*LOGQ + 1;
    localparam int LAT = calc_lat(LOGQ, LOGQH, FF_IN, FF_SUB, FF_MUL, FF_SUM, FF_OUT);

    // ---- input register
    logic [2*LOGQ-1:0] c_q;
    logic [LOGQH-1:0]  qh_q;

    generate
        if (FF_IN != 0) begin : g_in_ff
            always_ff @(posedge clk) begin
                if (rst) {c_q, qh_q} <= '0;
                else     {c_q, qh_q} <= {C, qH};
            end
        end else begin : g_in_wire
            assign {c_q, qh_q} = {C, qH};
        end
    endgenerate

    // ---- L iterations
    logic [TW-1:0]    t_ch  [L+1];
    logic [LOGQH-1:0] qh_ch [L+1];

    assign t_ch[0]  = {1'b0, c_q};
    assign qh_ch[0] = qh_q;

    generate
        for (genvar gi = 0; gi < L; gi++) begin : g_stage
            wlm_stage #(
                .LOGQ   (LOGQ),
                .LOGQH  (LOGQH),
                .FF_SUB (FF_SUB),
                .FF_MUL (FF_MUL),
                .FF_SUM (FF_SUM),
                .MIXED  (MIXED)
            ) u_stage (
                .clk    (clk),
                .rst    (rst),
                .t_in   (t_ch[gi]),
                .qh_in  (qh_ch[gi]),
                .t_out  (t_ch[gi+1]),
                .qh_out (qh_ch[gi+1])
            );
        end
    endgenerate

    // ---- final correction; q rebuilt from the qH that rode along.
    logic [LOGQ-1:0] q;
    logic [TW-1:0]   res;
    assign q = {qh_ch[L], {(W-1){1'b0}}, 1'b1};

    generate
        if (CORRECT != 0) begin : g_corr
            assign res = (t_ch[L] >= TW'(q)) ? (t_ch[L] - TW'(q)) : t_ch[L];
        end else begin : g_raw
            assign res = t_ch[L];
        end
    endgenerate

    // Upper bits are zero for C < q^2; q is only consumed when correcting.
    wire unused_hi = ^{res[TW-1:LOGQ], q};

    // ---- output register
    generate
        if (FF_OUT != 0) begin : g_out_ff
            always_ff @(posedge clk) begin
                if (rst) T <= '0;
                else     T <= res[LOGQ-1:0];
            end
        end else begin : g_out_wire
            assign T = res[LOGQ-1:0];
        end
    endgenerate

endmodule

// File: tb/tb_wlm_reducer.sv
// Bench for wlm_reducer: four small-modulus instances (LOGQ=8, LOGQH=4)
// covering full pipeline, raw output, combinational and output-only
// registering, plus two default-size instances (native and tiled multiply)
// fed identical random vectors. Expected values come from a full-width
// Montgomery model: T = (C + q*((-C*q^-1) mod R)) / R, R = 2^(W*L).
module tb_wlm_reducer;

    localparam int NCYC = 10300;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst;
    logic [3:0]   qs;
    logic [15:0]  cs;
    logic [7:0]   ta, tr, tc, td;
    logic [42:0]  qb;
    logic [119:0] cb;
    logic [59:0]  te0, te1;

    wlm_reducer #(.LOGQ(8), .LOGQH(4), .CORRECT(1)) dut_a (
        .clk(clk), .rst(rst), .qH(qs), .C(cs), .T(ta));
    wlm_reducer #(.LOGQ(8), .LOGQH(4), .CORRECT(0)) dut_r (
        .clk(clk), .rst(rst), .qH(qs), .C(cs), .T(tr));
    wlm_reducer #(.LOGQ(8), .LOGQH(4), .CORRECT(1), .FF_IN(0), .FF_SUB(0),
                  .FF_MUL(0), .FF_SUM(0), .FF_OUT(0)) dut_c (
        .clk(clk), .rst(rst), .qH(qs), .C(cs), .T(tc));
    wlm_reducer #(.LOGQ(8), .LOGQH(4), .CORRECT(1), .FF_IN(0), .FF_SUB(0),
                  .FF_MUL(0), .FF_SUM(0), .FF_OUT(1)) dut_d (
        .clk(clk), .rst(rst), .qH(qs), .C(cs), .T(td));
    wlm_reducer #(.MIXED(0)) dut_e0 (
        .clk(clk), .rst(rst), .qH(qb), .C(cb), .T(te0));
    wlm_reducer #(.MIXED(1)) dut_e1 (
        .clk(clk), .rst(rst), .qH(qb), .C(cb), .T(te1));

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Montgomery reduction by R = 2^rb, using q^-1 mod R via Newton iteration.
    function automatic logic [255:0] wlm_ref(input logic [255:0] c, input logic [255:0] q,
                                             input int rb, input bit corr);
        logic [255:0] mask, x, m, raw;
        mask = (256'd1 << rb) - 256'd1;
        x = 256'd1;
        repeat (8) x = (x * (256'd2 - q * x)) & mask;
        m = (256'd0 - c * x) & mask;
        raw = (c + q * m) >> rb;
        if (corr && raw >= q) raw = raw - q;
        return raw;
    endfunction

    logic [7:0]  ec [NCYC];
    logic [7:0]  er [NCYC];
    logic [59:0] eb [NCYC];
    int k = 1;

    function automatic logic [63:0] get_c(input int i);
        return (i >= 1) ? 64'(ec[i]) : 64'd0;
    endfunction
    function automatic logic [63:0] get_r(input int i);
        return (i >= 1) ? 64'(er[i]) : 64'd0;
    endfunction
    function automatic logic [63:0] get_b(input int i);
        return (i >= 1) ? 64'(eb[i]) : 64'd0;
    endfunction

    // Inputs are already applied; check comb instance, clock, check pipelines.
    task automatic cycle();
        logic [255:0] qsm, qbm;
        qsm = 256'(qs) * 256'd16 + 256'd1;
        qbm = (256'(qb) << 17) | 256'd1;
        ec[k] = 8'(wlm_ref(256'(cs), qsm, 8, 1'b1));
        er[k] = 8'(wlm_ref(256'(cs), qsm, 8, 1'b0));
        eb[k] = 60'(wlm_ref(256'(cb), qbm, 68, 1'b1));
        #1;
        chk("comb_lat0", 64'(tc), get_c(k));
        @(posedge clk);
        if (rst)
            for (int j = (k > 20 ? k - 20 : 1); j <= k; j++) begin
                ec[j] = '0; er[j] = '0; eb[j] = '0;
            end
        #1;
        chk("pipe_lat8", 64'(ta), get_c(k - 7));
        chk("raw_lat8",  64'(tr), get_r(k - 7));
        chk("out_lat1",  64'(td), get_c(k));
        chk("big_native", 64'(te0), get_b(k - 13));
        chk("big_tiled",  64'(te1), get_b(k - 13));
        k++;
    endtask

    task automatic rand_small();
        int qv, q;
        qv = $urandom_range(1, 7);
        q  = 16 * qv + 1;
        qs = 4'(qv);
        cs = 16'($urandom % (q * q));
    endtask

    task automatic rand_big(input bit edge_max, input logic [42:0] qfix);
        logic [63:0]  tmp;
        logic [127:0] q, q2, cc;
        tmp = {$urandom, $urandom};
        qb = edge_max ? qfix : tmp[42:0];
        if (qb == '0) qb = 43'd1;
        q  = (128'(qb) << 17) | 128'd1;
        q2 = q * q;
        cc = {$urandom, $urandom, $urandom, $urandom};
        cc = edge_max ? q2 - 128'd1 : cc % q2;
        cb = cc[119:0];
    endtask

    logic [15:0] dir_c [6] = '{16'h00C8, 16'h0120, 16'h0010, 16'h0000, 16'h0022, 16'h0011};

    initial begin
        rst = 1'b1; qs = 4'd1; cs = '0; qb = 43'd1; cb = '0;
        repeat (3) cycle();
        chk("lat_full",  64'(dut_a.LAT), 64'd8);
        chk("lat_comb",  64'(dut_c.LAT), 64'd0);
        chk("lat_out",   64'(dut_d.LAT), 64'd1);
        chk("lat_big",   64'(dut_e0.LAT), 64'd14);
        rst = 1'b0;

        // Directed small vectors with q = 17 back-to-back, big edge cases alongside.
        for (int i = 0; i < 6; i++) begin
            qs = 4'd1;
            cs = dir_c[i];
            if (i == 0)      rand_big(1'b1, '1);
            else if (i == 1) rand_big(1'b1, 43'd1);
            else if (i == 2) begin qb = 43'h123456789AB; cb = '0; end
            else             rand_big(1'b0, '0);
            cycle();
        end

        // Random stream with a one-cycle reset in the middle.
        for (int i = 0; i < 10000; i++) begin
            rand_small();
            rand_big(1'b0, '0);
            rst = (i == 50);
            cycle();
        end
        rst = 1'b0;

        // Drain the pipelines.
        cs = '0; qs = 4'd1; cb = '0; qb = 43'd1;
        repeat (20) cycle();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/wlm_reducer.md
Name: wlm_reducer

Overview:
Pipelined word-level Montgomery (WLM) reducer for NTT-friendly moduli q = qH*2^W + 1, where W = LOGQ-LOGQH. It takes a double-width product C and returns T = C*2^(-W*L) mod q, with L = ceil(LOGQ/W). It sits after the modular multiplier's integer multiplier in the butterfly datapath. It accepts one operand per cycle and has a fixed latency.

Parameters:
LOGQ, 60, modulus width in bits; C is 2*LOGQ bits.
LOGQH, 43, width of qH; W = LOGQ-LOGQH (17 by default), L = ceil(LOGQ/W) (4 by default).
CORRECT, 1, 1 = final conditional subtraction of q; 0 = output the raw value in [0,2q).
FF_IN, 1, register C and qH at the input.
FF_SUB, 1, register after the negate/carry step of each iteration.
FF_MUL, 1, register after the qH*T2 product of each iteration.
FF_SUM, 1, register after the accumulate step of each iteration.
FF_OUT, 1, register T at the output.
MIXED, 0, 0 = qH*T2 uses the native multiply operator; 1 = DSP-tiled decomposed multiply. Results are bit-identical.
Localparam LAT = FF_IN + L*(FF_SUB+FF_MUL+FF_SUM) + FF_OUT. LAT must be hierarchically readable as LAT.

Ports:
clk  in  1  clock; all registers update on its rising edge.
rst  in  1  synchronous reset, active-high.
qH  in  LOGQH  upper part of q; may change every cycle and travels with its C.
C  in  2*LOGQ  value to reduce; requires C < q^2.
T  out  LOGQ  reduced result.

Behaviour:
- Reset: while rst is high at a clock edge, every pipeline register clears to 0, so T=0 when FF_OUT=1. A mid-stream reset flushes all in-flight operands. Because a zero operand reduces to 0, T stays 0 until the first post-reset operand reaches the output. With all FF_*=0 the block is purely combinational and rst has no effect.
- Throughput: 1 operand per cycle, no handshake, no stalls. The operand presented before edge k appears on T after edge k+LAT-1. With LAT=0 it appears combinationally.
- Iteration i (0..L-1), starting from T = C:
  - SUB step: T1 = T[W-1:0]; T2 = (2^W - T1) mod 2^W; c = T1[W-1] | T2[W-1] (c=1 exactly when T1 != 0).
  - MUL step: P = qH*T2, width LOGQ.
  - SUM step: T = (T >> W) + P + c.
- qH must be pipelined alongside the data, so each stage uses its own operand's qH.
- Intermediate T is held at 2*LOGQ+1 bits with no truncation. Synthesis may trim provably-zero MSBs.
- Final step: if CORRECT=1 and T >= q (q rebuilt from the delayed qH), then T = T - q. This is combinational, ahead of the output register. Output is the low LOGQ bits.
- Guarantees for C < q^2: the result is in [0,q) when CORRECT=1 and in [0,2q) when CORRECT=0. With CORRECT=0, the caller guarantees 2q <= 2^LOGQ.
- Each stage has an independent FF enable; disabling a stage makes it a wire and reduces LAT accordingly.

Decomposition:
- Package wlm_pkg holds the functions calc_w(LOGQ,LOGQH), calc_l(LOGQ,LOGQH) and calc_lat(...).
- One natural sub-module, wlm_stage: one SUB/MUL/SUM iteration with its FF enables and MIXED selection. Instantiate it L times in a generate loop.

Test Plan:
Configuration for scenarios 1-4: LOGQ=8, LOGQH=4, qH=1 (q=17, W=4, L=2, 2^8 mod 17 = 1, so T = C mod 17), all FF=1, LAT=8.
1. C=0x00C8 -> T=13 (intermediate values: 21, then 13); C=0x0120 (q^2-1) -> T=16; C=0x0010 -> T=16; C=0 -> T=0.
2. C=0x0022, CORRECT=1 -> T=0; the same C with CORRECT=0 -> T=17 (raw, unsubtracted).
3. Stream the 6 vectors above on consecutive cycles -> each result appears exactly 8 edges later, in order, with no bubbles. Repeat with all FF=0 (LAT=0, combinational) and with only FF_OUT=1 (LAT=1).
4. Assert rst for 1 cycle mid-stream -> T=0 on the next edge; in-flight results are dropped; post-reset inputs emerge LAT edges after they are applied.
5. Default parameters (LOGQ=60, LOGQH=43): 10k random C < q^2 with random 43-bit qH per cycle -> T equals a golden model of C*2^(-68) mod q, LAT=14. Run the identical vector set with MIXED=0 and MIXED=1 and require identical outputs.
